rc4_ksa_engine: RTL and testbench

RC4_KSA_ENGINE -- requirements
Module: rc4_ksa_engine

---
 rtl/rc4_ksa_engine.sv | 197 +++++++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa_engine.sv
// rc4_ksa_engine
//   RC4 key-scheduling engine. It drives an external byte-wide S-memory with
//   a fixed read latency. It optionally fills S[i]=i, then performs the
//   256-step KSA swap loop using the key that was latched at start.
// Ports
//   clk, rst              : clock (rising edge), asynchronous active-high reset
//   start                 : one-cycle request, accepted in IDLE or DONE
//   abort                 : cancels a run in progress (returns to IDLE)
//   key[8*KEY_BYTES-1:0]  : secret key; byte 0 is in the most significant byte
//   mem_q                 : S-memory read data, valid RD_LAT cycles after address
//   mem_addr, mem_wdata   : S-memory address / write data
//   mem_wren              : S-memory write enable
//   busy, done            : status (busy outside IDLE/DONE, done only in DONE)
module rc4_ksa_engine #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned INIT_EN   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [7:0]             mem_q,
  output logic [7:0]             mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_wren,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FILL   = 4'd1;
  localparam logic [3:0] ST_RD_I   = 4'd2;
  localparam logic [3:0] ST_CALC_J = 4'd3;
  localparam logic [3:0] ST_RD_J   = 4'd4;
  localparam logic [3:0] ST_CAP_J  = 4'd5;
  localparam logic [3:0] ST_WR_I   = 4'd6;
  localparam logic [3:0] ST_WR_J   = 4'd7;
  localparam logic [3:0] ST_DONE   = 4'd8;

  logic [3:0]             state_q, state_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [KIDX_W-1:0]      kidx_q, kidx_d;
  logic [7:0]             si_q, si_d;
  logic [7:0]             sj_q, sj_d;
  logic [1:0]             lat_q, lat_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             key_byte;
  logic                   active;
  logic                   kill;

  assign active = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign kill   = abort && active;

  // Key byte selected by the wrapping index; a plain mux, no arithmetic.
  always_comb begin
    key_byte = '0;
    for (int unsigned b = 0; b < KEY_BYTES; b++) begin
      if (kidx_q == KIDX_W'(b)) begin
        key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    si_d    = si_q;
    sj_d    = sj_q;
    lat_d   = lat_q;
    key_d   = key_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          key_d   = key;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          lat_d   = '0;
          state_d = (INIT_EN != 0) ? ST_FILL : ST_RD_I;
        end
      end
      ST_FILL: begin
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d = ST_RD_I;
        end
      end
      ST_RD_I: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = ST_CALC_J;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      ST_CALC_J: begin
        si_d    = mem_q;
        j_d     = j_q + mem_q + key_byte;
        state_d = ST_RD_J;
      end
      ST_RD_J: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = ST_CAP_J;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      ST_CAP_J: begin
        sj_d    = mem_q;
        state_d = ST_WR_I;
      end
      ST_WR_I: begin
        state_d = ST_WR_J;
      end
      ST_WR_J: begin
        if (i_q == 8'hFF) begin
          state_d = ST_DONE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
          state_d = ST_RD_I;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (kill) begin
      state_d = ST_IDLE;
      lat_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      kidx_q  <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      lat_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      lat_q   <= lat_d;
      key_q   <= key_d;
    end
  end

  // Outputs decode from registered state only. The write enable is also
  // masked by abort, so an aborted cycle never writes.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state_q)
      ST_FILL: begin
        mem_addr  = i_q;
        mem_wdata = i_q;
        mem_wren  = 1'b1;
      end
      ST_RD_I, ST_CALC_J: mem_addr = i_q;
      ST_RD_J, ST_CAP_J:  mem_addr = j_q;
      ST_WR_I: begin
        mem_addr  = i_q;
        mem_wdata = sj_q;
        mem_wren  = 1'b1;
      end
      ST_WR_J: begin
        mem_addr  = j_q;
        mem_wdata = si_q;
        mem_wren  = 1'b1;
      end
      default: ;
    endcase
    if (kill) begin
      mem_wren = 1'b0;
    end
    busy = active;
    done = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// tb_rc4_ksa_engine
//   Self-checking bench for rc4_ksa_engine. Two instances share one clock:
//   dut0 uses KEY_BYTES=3 and RD_LAT=1, and dut1 uses KEY_BYTES=5 and RD_LAT=3.
//   Each instance has its own latency-accurate S-memory model.
module tb_rc4_ksa_engine;

  localparam int KB0 = 3, LAT0 = 1, KB1 = 5, LAT1 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1, abort0, abort1;
  logic [23:0] key0;
  logic [39:0] key1;
  logic [7:0]  q0, q1, addr0, addr1, wd0, wd1;
  logic        wren0, wren1, busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  rc4_ksa_engine #(.KEY_BYTES(KB0), .RD_LAT(LAT0), .INIT_EN(1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .key(key0),
    .mem_q(q0), .mem_addr(addr0), .mem_wdata(wd0), .mem_wren(wren0),
    .busy(busy0), .done(done0));

  rc4_ksa_engine #(.KEY_BYTES(KB1), .RD_LAT(LAT1), .INIT_EN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .key(key1),
    .mem_q(q1), .mem_addr(addr1), .mem_wdata(wd1), .mem_wren(wren1),
    .busy(busy1), .done(done1));

  // S-memory models: read data registered RD_LAT times after the address.
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] p1a, p1b, p1c;

  always @(posedge clk) begin
    if (wren0) mem0[addr0] <= wd0;
    q0 <= mem0[addr0];
  end

  always @(posedge clk) begin
    if (wren1) mem1[addr1] <= wd1;
    p1a <= mem1[addr1];
    p1b <= p1a;
    p1c <= p1b;
  end
  assign q1 = p1c;

  typedef struct {
    int         kind;   // 0 fill, 1 write of S[i], 2 write of S[j]
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int          sel;
    logic [39:0] key;
    logic [39:0] key2;
    bit          disturb;
    int          exp_n;
    bit          chk_ks;
  } vec_t;

  wr_t        sb0[$];
  wr_t        sb1[$];
  logic [7:0] exp_s [256];
  logic [7:0] ks_exp [10];
  int         n_checks = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_fill [2];
  int         last_wri [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, expv, expv, cyc);
    end
  endfunction

  // Pops one expected write per observed write and checks address, data and spacing.
  function automatic void mon(input int d, input logic we, input logic [7:0] a,
                              input logic [7:0] wd, input int lat);
    wr_t e;
    int  sz;
    if (!we) return;
    sz = (d == 0) ? sb0.size() : sb1.size();
    if (sz == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL unexpected_write dut%0d: got addr %0d data %0d, expected no write",
               d, a, wd);
      return;
    end
    e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
    check($sformatf("wr_addr dut%0d kind%0d", d, e.kind), int'(a), int'(e.addr));
    check($sformatf("wr_data dut%0d kind%0d", d, e.kind), int'(wd), int'(e.data));
    if (e.kind == 0) begin
      if (last_fill[d] >= 0) check($sformatf("fill_gap dut%0d", d), cyc - last_fill[d], 1);
      last_fill[d] = cyc;
    end else if (e.kind == 1) begin
      if (last_wri[d] >= 0) check($sformatf("iter_cycles dut%0d", d), cyc - last_wri[d], 2*lat + 4);
      last_wri[d] = cyc;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, wren0, addr0, wd0, LAT0);
      mon(1, wren1, addr1, wd1, LAT1);
    end
  end

  // Software KSA; fills the scoreboard with every write the engine must make.
  task automatic prep(input int d, input logic [39:0] k, input int nb);
    logic [7:0] s [256];
    logic [7:0] j, t, kb;
    wr_t        e;
    last_fill[d] = -1;
    last_wri[d]  = -1;
    if (d == 0) sb0.delete(); else sb1.delete();
    for (int i = 0; i < 256; i++) begin
      s[i] = i[7:0];
      e.kind = 0; e.addr = i[7:0]; e.data = i[7:0];
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    end
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = k[8*(nb-1-(i % nb)) +: 8];
      j = j + s[i] + kb;
      e.kind = 1; e.addr = i[7:0]; e.data = s[j];
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
      e.kind = 2; e.addr = j;      e.data = s[i];
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int a = 0; a < 256; a++) exp_s[a] = s[a];
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) start0 = v; else start1 = v;
  endtask

  task automatic set_abort(input int d, input logic v);
    if (d == 0) abort0 = v; else abort1 = v;
  endtask

  task automatic set_key(input int d, input logic [39:0] k);
    if (d == 0) key0 = k[23:0]; else key1 = k;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int         n, bad;
    logic [7:0] m [256];
    logic [7:0] pi, pj, t, ix;
    logic       dn, bz, we;
    set_key(v.sel, v.key);
    prep(v.sel, v.key, (v.sel == 0) ? KB0 : KB1);
    @(posedge clk); #1;
    set_start(v.sel, 1'b1);
    @(posedge clk); #1;          // edge 0: start sampled
    set_start(v.sel, 1'b0);
    n = 0;
    forever begin
      @(negedge clk);
      dn = (v.sel == 0) ? done0 : done1;
      bz = (v.sel == 0) ? busy0 : busy1;
      if (dn) break;
      if (n == 0) check($sformatf("busy_after_start v%0d", idx), int'(bz), 1);
      if (n > v.exp_n + 200) begin
        check($sformatf("done_timeout v%0d", idx), n, v.exp_n);
        break;
      end
      @(posedge clk); n++;
      #1;
      if (v.disturb) begin
        if (n == 50 || n == 600) begin
          set_key(v.sel, v.key2);
          set_start(v.sel, 1'b1);
        end else begin
          set_start(v.sel, 1'b0);
        end
      end
    end
    set_start(v.sel, 1'b0);
    check($sformatf("done_edge v%0d", idx), n, v.exp_n);
    check($sformatf("sb_empty v%0d", idx), (v.sel == 0) ? sb0.size() : sb1.size(), 0);
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      m[a] = (v.sel == 0) ? mem0[a] : mem1[a];
      if (m[a] != exp_s[a]) bad++;
    end
    check($sformatf("mem_contents v%0d", idx), bad, 0);
    // DONE holds, and abort there is ignored.
    @(posedge clk); #1;
    set_abort(v.sel, 1'b1);
    @(negedge clk);
    we = (v.sel == 0) ? wren0 : wren1;
    check($sformatf("done_hold_wren v%0d", idx), int'(we), 0);
    @(posedge clk); #1;
    set_abort(v.sel, 1'b0);
    @(negedge clk);
    dn = (v.sel == 0) ? done0 : done1;
    check($sformatf("done_after_abort v%0d", idx), int'(dn), 1);
    if (v.chk_ks) begin
      pi = 8'd0; pj = 8'd0;
      for (int r = 0; r < 10; r++) begin
        pi = pi + 8'd1;
        pj = pj + m[pi];
        t = m[pi]; m[pi] = m[pj]; m[pj] = t;
        ix = m[pi] + m[pj];
        check($sformatf("keystream[%0d] v%0d", r, idx), int'(m[ix]), int'(ks_exp[r]));
      end
    end
  endtask

  initial begin
    vec_t        tbl [6];
    logic [39:0] r0, r1;
    ks_exp = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    r0 = {8'($urandom), 32'($urandom)};
    r1 = {8'($urandom), 32'($urandom)};
    tbl[0] = '{0, 40'h4B6579, 40'h0,      1'b0, 1792, 1'b1};
    tbl[1] = '{0, 40'h4B6579, 40'hFFFFFF, 1'b1, 1792, 1'b1};
    tbl[2] = '{0, 40'h000000, 40'h0,      1'b0, 1792, 1'b0};
    tbl[3] = '{0, 40'hFFFFFF, 40'h0,      1'b0, 1792, 1'b0};
    tbl[4] = '{1, r0,         40'h0,      1'b0, 2816, 1'b0};
    tbl[5] = '{1, r1,         ~r1,        1'b1, 2816, 1'b0};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
    key0 = '0; key1 = '0;
    last_fill = '{-1, -1};
    last_wri  = '{-1, -1};
    repeat (2) @(negedge clk);
    check("reset_addr", int'(addr0), 0);
    check("reset_wdata", int'(wd0), 0);
    check("reset_wren_busy_done", int'({wren0, busy0, done0, wren1, busy1, done1}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", int'({busy0, done0}), 0);

    // Abort while writing S[100]: write suppressed, IDLE at the next edge.
    key0 = 24'h123456;
    prep(0, 40'h123456, KB0);
    @(posedge clk); #1; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (256 + 6*100 + 4) @(posedge clk);
    #1;
    abort0 = 1'b1;
    sb0.delete();
    @(negedge clk);
    check("abort_cycle_wren", int'(wren0), 0);
    check("abort_cycle_busy", int'(busy0), 1);
    @(posedge clk); #1;
    abort0 = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy0), 0);
    check("abort_done", int'(done0), 0);
    check("abort_addr", int'(addr0), 0);

    // Asynchronous reset at edge 500 of a run.
    key0 = 24'hA5C3F0;
    prep(0, 40'hA5C3F0, KB0);
    @(posedge clk); #1; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (499) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_addr", int'(addr0), 0);
    check("async_rst_wdata", int'(wd0), 0);
    check("async_rst_flags", int'({wren0, busy0, done0}), 0);
    sb0.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_midrun_reset", int'({busy0, done0}), 0);

    for (int k = 0; k < 6; k++) run_vec(k, tbl[k]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
